trigger_scheduler: RTL and testbench
====================================

Name: trigger_scheduler

Overview:
- Shares the single trigger-frame transmitter (the framer that sends idle/trigger frames) between NUM_SRC independent trigger requesters.
- Latches request edges, picks one source per trigger frame by round-robin, and drives the framer's trigger_pulse together with a per-source control code.
- Tracks frame boundaries to confirm the trigger frame went out, then enforces a frame-based holdoff before the next grant.

Parameters:
- NUM_SRC, 4: number of trigger requesters (2..8).
- HOLDOFF_FRAMES, 2: idle frames forced between consecutive trigger frames (0..15).
- CODE_BASE, 8'h08: control-byte code for source 0; source i uses CODE_BASE + i (8-bit wrap).
- TIMEOUT_CYCLES, 64: watchdog limit, used only with the optional feature.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- req  in  NUM_SRC  per-source trigger request; rising edge = one request.
- frame_start  in  1  1-cycle pulse from the framer when it emits byte 0 (SOP) of any frame.
- clear_dropped  in  1  synchronous clear of dropped[].
- trigger_pulse  out  1  registered 1-cycle request to the framer.
- trigger_code  out  8  code for the control byte; stable from trigger_pulse until the trigger frame completes.
- grant  out  NUM_SRC  one-hot source being served; zero when none.
- pending  out  NUM_SRC  latched, unserved requests.
- dropped  out  NUM_SRC  sticky: a request edge arrived while that source's pending bit was already set.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset (async, active-low): all outputs 0, FSM = IDLE, req_q = 0, rr_ptr = NUM_SRC-1 (first grant goes to source 0), counters 0.
- Edge detect: edge[i] = req[i] & ~req_q[i]. req_q is registered every cycle.
- Pending bits:
  - edge[i] sets pending[i].
  - The ARM entry clears pending[granted].
- Simultaneous events:
  - edge[i] in the same cycle that pending[i] is cleared by a grant: pending[i] stays 1, dropped[i] is not set.
  - edge[i] while pending[i] = 1 and not being cleared: dropped[i] <= 1.
  - clear_dropped in the same cycle as a new drop: the drop wins.
- Arbitration:
  - Round-robin search starts at rr_ptr+1 mod NUM_SRC.
  - The first pending index found wins.
  - rr_ptr <= winner on grant.
- FSM states:
  - IDLE: if any pending, go to ARM; latch winner into grant and trigger_code.
  - ARM (1 cycle): trigger_pulse = 1 (registered); go to WAIT_TX with fcnt = 0.
  - WAIT_TX: count frame_start pulses.
    - The 1st ends the in-flight frame; the 2nd marks the end of the trigger frame.
    - On the 2nd: clear grant and trigger_code to 0.
    - If HOLDOFF_FRAMES = 0, go to IDLE; otherwise go to HOLDOFF with hcnt = 0.
  - HOLDOFF: increment hcnt on each frame_start; go to IDLE when hcnt reaches HOLDOFF_FRAMES.
- A frame_start in the ARM cycle is counted by WAIT_TX (counter starts accumulating in ARM).
- Latency: req edge sampled at clock edge E0; pending visible after E0; ARM entered at E1; trigger_pulse high for the cycle after E1.
- Requests arriving in any non-IDLE state only set pending; they never preempt.
- Reset asserted mid-operation: immediate return to reset values; any partially sent trigger is abandoned (framer owns the recovery).
- trigger_pulse is never high for more than one consecutive cycle.
- Widths: frame and holdoff counters are 4 bits; code addition wraps modulo 256.

Optional Feature:
- Macro: TRIG_SCHED_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in WAIT_TX. If it reaches TIMEOUT_CYCLES before the 2nd frame_start, the FSM goes to IDLE, grant and trigger_code clear, and the extra output port timeout (1 bit, sticky, reset 0, cleared by clear_dropped) is set.
  - The granted request is lost; it is not re-pended.
- Not defined: no counter and no timeout port; WAIT_TX waits indefinitely.

Test Plan:
- Single request: pulse req[2] (NUM_SRC=4, CODE_BASE=8'h08), frame_start every 10 cycles -> trigger_pulse once, 2 cycles after the edge; trigger_code = 8'h0A; grant = 4'b0100 until the 2nd frame_start; busy clears after 2 further frame_starts (HOLDOFF_FRAMES=2).
- Round-robin: req = 4'b1011 rising together -> grants in order 0, 1, 3; codes 8'h08, 8'h09, 8'h0B; each trigger separated by ≥4 frame_starts.
- Drop: two req[1] edges before its grant -> dropped = 4'b0010 and only one trigger for source 1; clear_dropped -> dropped = 0.
- Edge on the grant cycle: req[0] edge coincides with the ARM entry for source 0 -> pending[0] stays 1, dropped[0] = 0, source 0 served again next.
- Reset mid-WAIT_TX: drop reset after 1 frame_start -> all outputs 0 immediately; after release, rr_ptr restarts and source 0 has first priority.
- With TRIG_SCHED_TIMEOUT_EN, TIMEOUT_CYCLES=64, frame_start held low -> timeout = 1 exactly 64 cycles into WAIT_TX; FSM returns to IDLE; grant = 0.

Source files
------------

// File: rtl/trigger_scheduler.sv
// Round-robin trigger arbiter sharing one trigger-frame transmitter.
// Optional macro TRIG_SCHED_TIMEOUT_EN adds a WAIT_TX watchdog and a timeout port.
module trigger_scheduler #(
  parameter int         NUM_SRC        = 4,
  parameter int         HOLDOFF_FRAMES = 2,
  parameter logic [7:0] CODE_BASE      = 8'h08,
  parameter int         TIMEOUT_CYCLES = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] req,
  input  logic               frame_start,
  input  logic               clear_dropped,
  output logic               trigger_pulse,
  output logic [7:0]         trigger_code,
  output logic [NUM_SRC-1:0] grant,
  output logic [NUM_SRC-1:0] pending,
  output logic [NUM_SRC-1:0] dropped,
`ifdef TRIG_SCHED_TIMEOUT_EN
  output logic               timeout,
`endif
  output logic               busy
);

  localparam int PW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    WAIT_TX,
    HOLDOFF
  } state_t;

  state_t             state;
  logic [NUM_SRC-1:0] req_q;
  logic [PW-1:0]      rr_ptr;
  logic [3:0]         fcnt;
  logic [3:0]         hcnt;
  logic [PW-1:0]      win;
  logic               any;
  logic [NUM_SRC-1:0] edges;
  logic [NUM_SRC-1:0] clr;
  logic [NUM_SRC-1:0] drop_set;

`ifdef TRIG_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt;
`endif

  // search starts one past the last winner
  always_comb begin
    win = '0;
    any = 1'b0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      if (!any && pending[PW'((int'(rr_ptr) + k) % NUM_SRC)]) begin
        any = 1'b1;
        win = PW'((int'(rr_ptr) + k) % NUM_SRC);
      end
    end
  end

  assign edges    = req & ~req_q;
  assign clr      = (state == IDLE && any) ? (NUM_SRC'(1) << win) : '0;
  assign drop_set = edges & pending & ~clr;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      req_q         <= '0;
      rr_ptr        <= PW'(NUM_SRC - 1);
      fcnt          <= '0;
      hcnt          <= '0;
      pending       <= '0;
      dropped       <= '0;
      grant         <= '0;
      trigger_code  <= '0;
      trigger_pulse <= 1'b0;
`ifdef TRIG_SCHED_TIMEOUT_EN
      tcnt          <= '0;
      timeout       <= 1'b0;
`endif
    end else begin
      req_q         <= req;
      pending       <= (pending & ~clr) | edges;
      dropped       <= (clear_dropped ? '0 : dropped) | drop_set;
      trigger_pulse <= 1'b0;
`ifdef TRIG_SCHED_TIMEOUT_EN
      if (clear_dropped) timeout <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          if (any) begin
            state         <= ARM;
            grant         <= NUM_SRC'(1) << win;
            trigger_code  <= CODE_BASE + 8'(win);
            rr_ptr        <= win;
            trigger_pulse <= 1'b1;
          end
        end
        ARM: begin
          state <= WAIT_TX;
          fcnt  <= frame_start ? 4'd1 : 4'd0;
`ifdef TRIG_SCHED_TIMEOUT_EN
          tcnt  <= '0;
`endif
        end
        WAIT_TX: begin
          // second SOP closes the trigger frame
          if (frame_start && fcnt != 4'd0) begin
            grant        <= '0;
            trigger_code <= '0;
            fcnt         <= '0;
            hcnt         <= '0;
            state        <= (HOLDOFF_FRAMES == 0) ? IDLE : HOLDOFF;
          end
`ifdef TRIG_SCHED_TIMEOUT_EN
          else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
            grant        <= '0;
            trigger_code <= '0;
            fcnt         <= '0;
            timeout      <= 1'b1;
            state        <= IDLE;
          end
`endif
          else begin
            if (frame_start) fcnt <= fcnt + 4'd1;
`ifdef TRIG_SCHED_TIMEOUT_EN
            tcnt <= tcnt + TW'(1);
`endif
          end
        end
        HOLDOFF: begin
          if (frame_start) begin
            hcnt <= hcnt + 4'd1;
            if (hcnt + 4'd1 == 4'(HOLDOFF_FRAMES)) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trigger_scheduler.sv
// Directed bench for trigger_scheduler (NUM_SRC=4, HOLDOFF_FRAMES=2, CODE_BASE=8'h08).
// Timeout scenario is included when TRIG_SCHED_TIMEOUT_EN is defined.
module tb_trigger_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic       frame_start;
  logic       clear_dropped;
  logic       trigger_pulse;
  logic [7:0] trigger_code;
  logic [3:0] grant;
  logic [3:0] pending;
  logic [3:0] dropped;
  logic       busy;
`ifdef TRIG_SCHED_TIMEOUT_EN
  logic       timeout;
`endif

  int total = 0;
  int bad   = 0;

  trigger_scheduler #(
    .NUM_SRC(4),
    .HOLDOFF_FRAMES(2),
    .CODE_BASE(8'h08),
    .TIMEOUT_CYCLES(64)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .frame_start(frame_start),
    .clear_dropped(clear_dropped),
    .trigger_pulse(trigger_pulse),
    .trigger_code(trigger_code),
    .grant(grant),
    .pending(pending),
    .dropped(dropped),
`ifdef TRIG_SCHED_TIMEOUT_EN
    .timeout(timeout),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    reset         = 1'b0;
    req           = '0;
    frame_start   = 1'b0;
    clear_dropped = 1'b0;
    tick();
    reset = 1'b1;
    tick();
  endtask

  initial begin
    reset         = 1'b0;
    req           = '0;
    frame_start   = 1'b0;
    clear_dropped = 1'b0;
    tick(2);
    check("rst_busy", busy, 0);
    check("rst_grant", grant, 0);
    check("rst_pend", pending, 0);
    check("rst_tp", trigger_pulse, 0);
    check("rst_code", trigger_code, 0);
    check("rst_drop", dropped, 0);
    reset = 1'b1;
    tick();

    // single request from source 2
    req = 4'b0100;
    tick();
    check("s1_pend", pending, 4'b0100);
    check("s1_tp_early", trigger_pulse, 0);
    tick();
    check("s1_tp", trigger_pulse, 1);
    check("s1_grant", grant, 4'b0100);
    check("s1_code", trigger_code, 8'h0A);
    check("s1_pend_clr", pending, 0);
    req = '0;
    tick();
    check("s1_tp_one", trigger_pulse, 0);
    check("s1_busy", busy, 1);
    frame();
    check("s1_grant_f1", grant, 4'b0100);
    check("s1_code_f1", trigger_code, 8'h0A);
    frame();
    check("s1_grant_f2", grant, 0);
    check("s1_code_f2", trigger_code, 0);
    check("s1_busy_f2", busy, 1);
    frame();
    check("s1_busy_f3", busy, 1);
    frame();
    check("s1_busy_f4", busy, 0);

    // round robin over 4'b1011
    do_reset();
    req = 4'b1011;
    tick(2);
    check("rr_g0", grant, 4'b0001);
    check("rr_c0", trigger_code, 8'h08);
    check("rr_tp0", trigger_pulse, 1);
    tick();
    repeat (4) frame();
    check("rr_g1", grant, 4'b0010);
    check("rr_c1", trigger_code, 8'h09);
    check("rr_tp1", trigger_pulse, 1);
    tick();
    repeat (3) frame();
    check("rr_hold", busy, 1);
    frame();
    check("rr_g3", grant, 4'b1000);
    check("rr_c3", trigger_code, 8'h0B);
    tick();
    repeat (4) frame();
    check("rr_idle", busy, 0);
    check("rr_pend", pending, 0);

    // drop on second edge while pending
    do_reset();
    req = 4'b0001;
    tick(2);
    req = 4'b0011;
    tick();
    req = 4'b0001;
    tick();
    req = 4'b0011;
    tick();
    check("dr_drop", dropped, 4'b0010);
    check("dr_pend", pending, 4'b0010);
    req = '0;
    repeat (4) frame();
    check("dr_grant", grant, 4'b0010);
    tick();
    repeat (4) frame();
    check("dr_idle", busy, 0);
    check("dr_pend_done", pending, 0);
    check("dr_drop_keep", dropped, 4'b0010);
    clear_dropped = 1'b1;
    tick();
    clear_dropped = 1'b0;
    check("dr_clear", dropped, 0);

    // edge coincides with grant of the same source
    do_reset();
    req = 4'b0010;
    tick(2);
    req = 4'b0011;
    tick();
    req = 4'b0010;
    tick();
    check("eg_pend0", pending, 4'b0001);
    repeat (3) frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    req = 4'b0011;
    tick();
    check("eg_grant", grant, 4'b0001);
    check("eg_pend", pending, 4'b0001);
    check("eg_drop", dropped, 0);
    req = 4'b0010;
    tick();
    repeat (4) frame();
    check("eg_again", grant, 4'b0001);
    check("eg_tp", trigger_pulse, 1);
    check("eg_pend_done", pending, 0);

    // reset during WAIT_TX
    do_reset();
    req = 4'b0100;
    tick(3);
    frame();
    check("mr_pre", grant, 4'b0100);
    reset = 1'b0;
    #1;
    check("mr_grant", grant, 0);
    check("mr_busy", busy, 0);
    check("mr_code", trigger_code, 0);
    check("mr_pend", pending, 0);
    req = '0;
    tick();
    reset = 1'b1;
    tick();
    req = 4'b0101;
    tick(2);
    check("mr_first", grant, 4'b0001);
    tick();

`ifdef TRIG_SCHED_TIMEOUT_EN
    tick(63);
    check("to_not_yet", timeout, 0);
    check("to_busy", busy, 1);
    tick();
    check("to_set", timeout, 1);
    check("to_grant", grant, 0);
    check("to_idle", busy, 0);
    clear_dropped = 1'b1;
    tick();
    clear_dropped = 1'b0;
    check("to_clear", timeout, 0);
`else
    tick(70);
    check("nt_busy", busy, 1);
    check("nt_grant", grant, 4'b0001);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
